// File: rtl/bus_mem_responder.sv
// bus_mem_responder: word memory answering cpu bus requests with a memOpDone handshake.
// Access latency is programmable via LATENCY (0..15 wait cycles).
// Optional build macro MEM_BUS_ERR_EN: out-of-range addresses raise memErr, suppress
// writes and read back 32'hDEAD_BEEF. Without it the word index wraps modulo DEPTH
// and memErr stays 0.
module bus_mem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memReq,
   input  logic        memRWPin,
   input  logic [31:0] addressBus,
   inout  wire  [31:0] dataBus,
   output logic        memOpDone,
   output logic        memErr
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic                accept_c;
   logic                commit_c;
   logic                addr_err_c;
   logic                unused_c;

   logic [ADDR_W-1:0]   idx_q;
   logic                rw_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                err_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                drive_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Out-of-range detection; address bits above the word index only matter with the error feature
`ifdef MEM_BUS_ERR_EN
   assign addr_err_c = (addressBus[31:ADDR_W+2] != '0);
`else
   assign addr_err_c = 1'b0;
`endif
   assign unused_c = ^{addressBus[31:ADDR_W+2], addressBus[1:0]};

   // Next-state logic: accept, latency countdown, response, hold until memReq drops
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept_c   = 1'b0;
      commit_c   = 1'b0;
      case (state)
         IDLE: begin
            if (memReq) begin
               state_next = WAIT;
               cnt_next   = CNT_W'(LATENCY);
               accept_c   = 1'b1;
            end
         end
         WAIT: begin
            if (!memReq) begin
               state_next = IDLE;
            end else if (cnt == '0) begin
               state_next = RESP;
               commit_c   = 1'b1;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            state_next = memReq ? HOLD : IDLE;
         end
         HOLD: begin
            if (!memReq) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and registered handshake/bus-enable outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         memOpDone <= 1'b0;
         memErr    <= 1'b0;
         drive_q   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         memOpDone <= commit_c;
         memErr    <= commit_c & err_q;
         drive_q   <= ((state_next == RESP) || (state_next == HOLD)) && !rw_q;
      end
   end

   // Request capture at accept; later bus changes are ignored
   always_ff @(posedge clk) begin
      if (accept_c && !reset) begin
         idx_q   <= addressBus[ADDR_W+1:2];
         rw_q    <= memRWPin;
         wdata_q <= dataBus;
         err_q   <= addr_err_c;
      end
   end

   // Array access on entry to RESP; a reset before that point discards the access
   always_ff @(posedge clk) begin
      if (commit_c && !reset) begin
         if (rw_q) begin
            if (!err_q) begin
               mem[idx_q] <= wdata_q;
            end
         end else begin
            rdata_q <= err_q ? 32'hDEAD_BEEF : mem[idx_q];
         end
      end
   end

   assign dataBus = drive_q ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder with a queue-based scoreboard and reference word model.
module tb_bus_mem_responder;

   localparam int unsigned LATENCY = 2;
   localparam int unsigned AW      = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic        mem_rw;
   logic [31:0] address;
   logic        tb_drive;
   logic [31:0] tb_data;
   wire  [31:0] data_bus;
   logic        mem_op_done;
   logic        mem_err;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [int];
   int          total = 0;
   int          bad   = 0;

   assign data_bus = tb_drive ? tb_data : 32'hzzzz_zzzz;

   always #5 clk = ~clk;

   bus_mem_responder #(.DEPTH(1024), .ADDR_W(AW), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .reset      (reset),
      .memReq     (mem_req),
      .memRWPin   (mem_rw),
      .addressBus (address),
      .dataBus    (data_bus),
      .memOpDone  (mem_op_done),
      .memErr     (mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic addr_err(input logic [31:0] a);
`ifdef MEM_BUS_ERR_EN
      return (a[31:AW+2] != '0);
`else
      return 1'b0;
`endif
   endfunction

   // With the DUT idle, drive zero onto the bus; any leftover DUT drive corrupts it
   task automatic chk_release(input string tag);
      tb_drive = 1'b1;
      tb_data  = 32'h0;
      #1;
      chk(tag, data_bus, 32'h0);
      tb_drive = 1'b0;
   endtask

   task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic drop_resp, input string tag);
      exp_t e;
      exp_t got;
      int   k;
      logic seen;
      e.err = addr_err(addr);
      if (rw) begin
         e.data = 32'h0;
         if (!e.err) model[int'(addr[AW+1:2])] = wdata;
      end else begin
         e.data = e.err ? 32'hDEAD_BEEF : model[int'(addr[AW+1:2])];
      end
      sb.push_back(e);
      mem_req  = 1'b1;
      mem_rw   = rw;
      address  = addr;
      tb_drive = rw;
      tb_data  = wdata;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            // Disturb inputs after accept; the latched copies must be used
            tb_data = ~wdata;
            address = addr ^ 32'h0000_0ffc;
            mem_rw  = ~rw;
         end
         if (mem_op_done) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'h1);
      if (!seen) begin
         mem_req  = 1'b0;
         tb_drive = 1'b0;
         if (sb.size() > 0) got = sb.pop_front();
         repeat (2) @(negedge clk);
         return;
      end
      tb_drive = 1'b0;
      got = sb.pop_front();
      chk({tag, "_latency"}, 32'(k - 1), 32'(LATENCY + 1));
      chk({tag, "_err"}, 32'(mem_err), 32'(got.err));
      if (!rw) chk({tag, "_rdata_resp"}, data_bus, got.data);
      if (drop_resp) begin
         mem_req = 1'b0;
         @(negedge clk);
         chk({tag, "_single_pulse"}, 32'(mem_op_done), 32'h0);
      end else begin
         @(negedge clk);
         chk({tag, "_single_pulse"}, 32'(mem_op_done), 32'h0);
         if (!rw) chk({tag, "_rdata_hold"}, data_bus, got.data);
         mem_req = 1'b0;
         @(negedge clk);
      end
      chk_release({tag, "_release"});
   endtask

   task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic use_reset, input string tag);
      logic pulse;
      mem_req  = 1'b1;
      mem_rw   = 1'b1;
      address  = addr;
      tb_drive = 1'b1;
      tb_data  = wdata;
      @(negedge clk);
      if (use_reset) reset = 1'b1;
      else mem_req = 1'b0;
      @(negedge clk);
      pulse    = mem_op_done;
      reset    = 1'b0;
      mem_req  = 1'b0;
      tb_drive = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (mem_op_done) pulse = 1'b1;
      end
      chk({tag, "_no_pulse"}, 32'(pulse), 32'h0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rd;
      reset    = 1'b1;
      mem_req  = 1'b0;
      mem_rw   = 1'b0;
      address  = 32'h0;
      tb_drive = 1'b0;
      tb_data  = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_done", 32'(mem_op_done), 32'h0);
      chk("reset_err", 32'(mem_err), 32'h0);
      chk_release("reset_bus");
      reset = 1'b0;
      @(negedge clk);

      do_access(1'b1, 32'h10, 32'h0000_1234, 1'b0, "wr10");
      do_access(1'b0, 32'h10, 32'h0,         1'b0, "rd10");

      do_access(1'b1, 32'h20, 32'h0000_1111, 1'b0, "wr20_prior");
      abort_write(32'h20, 32'hAAAA_5555, 1'b1, "rst_wait20");
      do_access(1'b0, 32'h20, 32'h0,         1'b0, "rd20");

      do_access(1'b1, 32'h30, 32'h0000_3333, 1'b0, "wr30_prior");
      abort_write(32'h30, 32'h0BAD_0BAD, 1'b0, "drop_wait30");
      do_access(1'b0, 32'h30, 32'h0,         1'b0, "rd30");

      do_access(1'b1, 32'h40, 32'h0000_0007, 1'b0, "wr40");
      do_access(1'b0, 32'h40, 32'h0,         1'b0, "rd40");
      do_access(1'b0, 32'h41, 32'h0,         1'b0, "rd41");

      do_access(1'b1, 32'h50, 32'h0000_0055, 1'b1, "wr50_droprsp");
      do_access(1'b0, 32'h50, 32'h0,         1'b1, "rd50_droprsp");

      do_access(1'b1, 32'h0,    32'h0000_0005, 1'b0, "wr0");
      do_access(1'b1, 32'h1000, 32'h0000_0009, 1'b0, "wr1000");
      do_access(1'b0, 32'h1000, 32'h0,         1'b0, "rd1000");
      do_access(1'b0, 32'h0,    32'h0,         1'b0, "rd0");

      for (int i = 0; i < 4; i++) begin
         ra = {20'h0, 6'($urandom_range(0, 63)), 2'b00} + 32'h100;
         rd = $urandom;
         do_access(1'b1, ra, rd,    1'b0, "rnd_wr");
         do_access(1'b0, ra, 32'h0, 1'b0, "rnd_rd");
      end

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
